prog_loader_ctrl: RTL and testbench
===================================

Name: prog_loader_ctrl

Overview:
- Sequences program loading into the 16x8 program RAM of the 8-bit CPU.
- Accepts a byte stream on a valid/ready handshake and writes the bytes to consecutive RAM addresses starting at 0. Holds the CPU in reset while loading, optionally zero-fills the unused addresses, then releases the CPU.
- Arbitrates the single RAM address/write port: the CPU's MAR owns it when idle, the loader owns it during a load.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM/bus data width.
- DEPTH, 16, number of RAM words; must equal 2**ADDR_W.
- ZERO_FILL, 1, 1 = write 0 to addresses len..DEPTH-1 after the last byte; 0 = leave them untouched.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- load_req  in  1  start pulse; sampled only in IDLE
- load_len  in  ADDR_W+1  byte count, sampled with load_req; legal range 1..DEPTH
- load_abort  in  1  cancels an active load
- in_valid  in  1  stream byte valid
- in_data  in  DATA_W  stream byte
- in_ready  out  1  loader accepts a byte
- cpu_addr  in  ADDR_W  CPU MAR value
- ram_addr  out  ADDR_W  address to RAM
- ram_wdata  out  DATA_W  write data to RAM
- ram_we  out  1  RAM write enable
- cpu_hold  out  1  holds the CPU in reset (ORed into CPU rst at top level)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on illegal length or abort

Behaviour:
- Decided: reset rst, asynchronous, active-high; clock clk.
- States: IDLE, LOAD, FILL, RELEASE.
- Registers: state, cnt[ADDR_W:0], len[ADDR_W:0], done, err.
- Reset values: state=IDLE, cnt=0, len=0, done=0, err=0. Outputs while in reset: in_ready=0, ram_we=0, cpu_hold=0, busy=0, ram_addr=cpu_addr.
- IDLE:
  - ram_addr=cpu_addr, ram_we=0, ram_wdata=0, in_ready=0, cpu_hold=0.
  - load_req with 1<=load_len<=DEPTH: len<=load_len, cnt<=0, go to LOAD.
  - load_req with load_len=0 or load_len>DEPTH: err pulses the next cycle; stay in IDLE.
- LOAD:
  - in_ready=1, cpu_hold=1, ram_addr=cnt[ADDR_W-1:0], ram_wdata=in_data.
  - ram_we = in_valid, combinational, so a write happens in the same cycle as the handshake.
  - Each transfer increments cnt.
  - Transfer with cnt==len-1:
    - ZERO_FILL=1 and len<DEPTH: go to FILL.
    - Otherwise: go to RELEASE.
  - in_valid low: hold state, no write.
- FILL:
  - in_ready=0, ram_we=1, ram_wdata=0, ram_addr=cnt[ADDR_W-1:0]; cnt increments every cycle.
  - When cnt==DEPTH-1: go to RELEASE.
  - Takes DEPTH-len cycles.
- RELEASE:
  - One cycle. cpu_hold=1, ram_we=0, in_ready=0, done=1 (registered on entry).
  - Next state IDLE; cpu_hold falls entering IDLE.
- Abort:
  - load_abort in LOAD or FILL goes to IDLE next cycle and pulses err.
  - No write occurs in the abort cycle: ram_we and in_ready are forced 0 while load_abort=1.
  - Already-written bytes remain in RAM.
  - Abort outranks a simultaneous final transfer.
  - load_abort in IDLE or RELEASE is ignored.
- load_req outside IDLE is ignored (no err).
- done and err are never high together.
- busy = (state != IDLE).
- cnt never exceeds DEPTH; address wraps are impossible by construction.
- Asynchronous reset mid-load: immediately IDLE, cpu_hold=0, ram_we=0; partial RAM contents are undefined to the program.

Test Plan:
- load_req, len=3; bytes 0x1E,0x2F,0xE0 back-to-back; ZERO_FILL=0 -> ram_we at addr 0,1,2 in three consecutive cycles; RELEASE; done one cycle; cpu_hold high from cycle after load_req until done cycle inclusive.
- len=2 with an in_valid gap of 3 cycles between bytes -> no ram_we during the gap; addr 0,1 written once each; done after the 2nd byte.
- ZERO_FILL=1, len=14 -> after byte 14, two FILL cycles write 0 to addr 14,15; then done; total busy = 14 transfer cycles + 2 + 1.
- load_len=0 and load_len=17 -> err pulse; busy stays 0; no ram_we; cpu_hold=0.
- load_abort on the 2nd byte of len=4 -> no write at addr 1; err pulse; IDLE; ram_addr follows cpu_addr=0x9 next cycle.
- rst asserted mid-FILL -> same-cycle cpu_hold=0, ram_we=0, busy=0; new load_req afterwards completes normally.

Source files
------------

// File: rtl/prog_loader_ctrl.sv
// prog_loader_ctrl: loads a byte stream into the CPU program RAM.
// Bytes are written to consecutive addresses starting at 0. The CPU is held
// in reset for the whole load. With ZERO_FILL set, the addresses after the
// last byte are cleared. The CPU is then released.
// The single RAM address/write port belongs to the CPU MAR while idle and to
// the loader while a load is running.
//
// Handshake: a stream byte transfers in any cycle where in_valid && in_ready.
// in_valid may be held or dropped freely by the source. in_ready is high only
// in LOAD and never in a cycle where load_abort is high.
module prog_loader_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int ZERO_FILL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_FILL    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

    state_t          state_q, state_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic [ADDR_W:0] len_q, len_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    // Next-state logic and the port-arbitration / handshake outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        in_ready  = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        ram_addr  = cpu_addr;
        cpu_hold  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    if ((load_len != '0) && (load_len <= DEPTH_C)) begin
                        len_d   = load_len;
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                cpu_hold  = 1'b1;
                ram_addr  = cnt_q[ADDR_W-1:0];
                ram_wdata = in_data;
                // Abort wins over a transfer in the same cycle, including the final one.
                if (load_abort) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    in_ready = 1'b1;
                    ram_we   = in_valid;
                    if (in_valid) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == len_q - 1'b1) begin
                            if ((ZERO_FILL != 0) && (len_q < DEPTH_C)) begin
                                state_d = S_FILL;
                            end else begin
                                state_d = S_RELEASE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
            end

            S_FILL: begin
                cpu_hold = 1'b1;
                ram_addr = cnt_q[ADDR_W-1:0];
                if (load_abort) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    ram_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_C) begin
                        state_d = S_RELEASE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_RELEASE: begin
                // The CPU stays held for this one cycle while done is visible.
                cpu_hold = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and pulse registers; reset drops straight to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Bench for prog_loader_ctrl: two instances (ZERO_FILL=0 and ZERO_FILL=1)
// share one stimulus stream. Each instance has its own RAM image built from
// the writes it issues, and an expected image built from the load rules.
module tb_prog_loader_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_req;
    logic [4:0] load_len;
    logic       load_abort;
    logic       in_valid;
    logic [7:0] in_data;
    logic [3:0] cpu_addr;

    logic       in_ready_0, ram_we_0, cpu_hold_0, busy_0, done_0, err_0;
    logic [3:0] ram_addr_0;
    logic [7:0] ram_wdata_0;
    logic       in_ready_1, ram_we_1, cpu_hold_1, busy_1, done_1, err_1;
    logic [3:0] ram_addr_1;
    logic [7:0] ram_wdata_1;

    int checks   = 0;
    int failures = 0;

    // sampled outputs of the last step, index = instance
    bit         s_busy [2];
    bit         s_hold [2];
    bit         s_done [2];
    bit         s_err  [2];
    bit         s_rdy  [2];
    bit         s_we   [2];
    logic [3:0] s_addr [2];

    logic [7:0] ram_m [2][16];
    logic [7:0] exp_m [2][16];
    int         wr_cnt [2];
    logic [7:0] data_b [16];

    typedef struct {
        int len;
        bit exp_busy;
        bit exp_err_req;
        bit exp_err_abort;
    } vec_t;
    vec_t vecs [6];

    prog_loader_ctrl #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .ZERO_FILL(0)) u0 (
        .clk(clk), .rst(rst), .load_req(load_req), .load_len(load_len),
        .load_abort(load_abort), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_0), .cpu_addr(cpu_addr), .ram_addr(ram_addr_0),
        .ram_wdata(ram_wdata_0), .ram_we(ram_we_0), .cpu_hold(cpu_hold_0),
        .busy(busy_0), .done(done_0), .err(err_0)
    );

    prog_loader_ctrl #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .ZERO_FILL(1)) u1 (
        .clk(clk), .rst(rst), .load_req(load_req), .load_len(load_len),
        .load_abort(load_abort), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_1), .cpu_addr(cpu_addr), .ram_addr(ram_addr_1),
        .ram_wdata(ram_wdata_1), .ram_we(ram_we_1), .cpu_hold(cpu_hold_1),
        .busy(busy_1), .done(done_1), .err(err_1)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Inputs are set at the falling edge; sample 1ns later, log RAM writes,
    // then advance to the next falling edge (the rising edge falls in between).
    task automatic step();
        #1;
        s_busy[0] = busy_0;     s_busy[1] = busy_1;
        s_hold[0] = cpu_hold_0; s_hold[1] = cpu_hold_1;
        s_done[0] = done_0;     s_done[1] = done_1;
        s_err[0]  = err_0;      s_err[1]  = err_1;
        s_rdy[0]  = in_ready_0; s_rdy[1]  = in_ready_1;
        s_we[0]   = ram_we_0;   s_we[1]   = ram_we_1;
        s_addr[0] = ram_addr_0; s_addr[1] = ram_addr_1;
        if (ram_we_0) begin
            ram_m[0][ram_addr_0] = ram_wdata_0;
            wr_cnt[0]++;
        end
        if (ram_we_1) begin
            ram_m[1][ram_addr_1] = ram_wdata_1;
            wr_cnt[1]++;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        load_req   = 1'b0;
        load_abort = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'($urandom);
        load_len   = 5'($urandom);
    endtask

    // One complete load of data_b[0..len-1], optionally aborted on byte abort_at.
    // The expected behaviour comes from the load rules: the per-cycle stream
    // schedule gives the LOAD duration, FILL lasts 16-len cycles on the
    // zero-fill instance, and RELEASE lasts one cycle.
    task automatic run_load(input int len, input bit do_abort, input int abort_at,
                            input int gap_fix, input int gap_rnd);
        bit         v_s [$];
        bit         a_s [$];
        logic [7:0] d_s [$];
        int last, load_cycles, n_wr, fill1, total, min_busy, gap;
        int exp_busy [2];
        int bm [2], hm [2], rm [2], am [2];
        int done_n [2], done_at [2], err_n [2], err_at [2];
        int diff;

        last = do_abort ? abort_at : len - 1;
        for (int i = 0; i <= last; i++) begin
            if (i > 0) begin
                gap = gap_fix + ((gap_rnd > 0) ? int'($urandom_range(0, gap_rnd)) : 0);
                for (int g = 0; g < gap; g++) begin
                    v_s.push_back(1'b0); a_s.push_back(1'b0); d_s.push_back(8'($urandom));
                end
            end
            v_s.push_back(1'b1);
            a_s.push_back(do_abort && (i == abort_at));
            d_s.push_back(data_b[i]);
        end
        load_cycles = v_s.size();
        n_wr        = do_abort ? abort_at : len;
        fill1       = do_abort ? 0 : 16 - len;
        exp_busy[0] = load_cycles + (do_abort ? 0 : 1);
        exp_busy[1] = load_cycles + (do_abort ? 0 : fill1 + 1);
        total       = exp_busy[1] + 2;
        min_busy    = exp_busy[0];

        for (int i = 0; i < n_wr; i++) begin
            exp_m[0][i] = data_b[i];
            exp_m[1][i] = data_b[i];
        end
        if (!do_abort) begin
            for (int i = len; i < 16; i++) exp_m[1][i] = 8'h00;
        end

        for (int j = 0; j < 2; j++) begin
            wr_cnt[j] = 0; bm[j] = 0; hm[j] = 0; rm[j] = 0; am[j] = 0;
            done_n[j] = 0; done_at[j] = -1; err_n[j] = 0; err_at[j] = -1;
        end

        idle_inputs();
        load_req = 1'b1;
        load_len = 5'(len);
        cpu_addr = 4'($urandom);
        step();
        check("req_cycle_busy0", s_busy[0], 0);
        check("req_cycle_addr0", s_addr[0], cpu_addr);

        for (int k = 0; k < total; k++) begin
            idle_inputs();
            if (k < load_cycles) begin
                in_valid   = v_s[k];
                load_abort = a_s[k];
                in_data    = d_s[k];
            end
            // requests while busy must be ignored
            if (k < min_busy - 1) load_req = 1'($urandom);
            cpu_addr = 4'($urandom);
            step();
            for (int j = 0; j < 2; j++) begin
                if (s_busy[j] != (k < exp_busy[j])) bm[j]++;
                if (s_hold[j] != (k < exp_busy[j])) hm[j]++;
                if (s_rdy[j] != ((k < load_cycles) && !a_s[k % load_cycles])) rm[j]++;
                if ((k >= exp_busy[j]) && (s_addr[j] != cpu_addr)) am[j]++;
                if (s_done[j]) begin done_n[j]++; done_at[j] = k; end
                if (s_err[j])  begin err_n[j]++;  err_at[j] = k;  end
            end
        end

        for (int j = 0; j < 2; j++) begin
            diff = 0;
            for (int a = 0; a < 16; a++) if (ram_m[j][a] !== exp_m[j][a]) diff++;
            check($sformatf("busy_trace%0d", j), bm[j], 0);
            check($sformatf("hold_trace%0d", j), hm[j], 0);
            check($sformatf("ready_trace%0d", j), rm[j], 0);
            check($sformatf("idle_addr%0d", j), am[j], 0);
            check($sformatf("done_count%0d", j), done_n[j], do_abort ? 0 : 1);
            check($sformatf("done_cycle%0d", j), done_at[j], do_abort ? -1 : exp_busy[j] - 1);
            check($sformatf("err_count%0d", j), err_n[j], do_abort ? 1 : 0);
            check($sformatf("err_cycle%0d", j), err_at[j], do_abort ? load_cycles : -1);
            check($sformatf("write_count%0d", j), wr_cnt[j], n_wr + ((j == 1) ? fill1 : 0));
            check($sformatf("ram_diff%0d", j), diff, 0);
        end
    endtask

    initial begin
        vecs[0] = '{len: 0,  exp_busy: 1'b0, exp_err_req: 1'b1, exp_err_abort: 1'b0};
        vecs[1] = '{len: 17, exp_busy: 1'b0, exp_err_req: 1'b1, exp_err_abort: 1'b0};
        vecs[2] = '{len: 31, exp_busy: 1'b0, exp_err_req: 1'b1, exp_err_abort: 1'b0};
        vecs[3] = '{len: 1,  exp_busy: 1'b1, exp_err_req: 1'b0, exp_err_abort: 1'b1};
        vecs[4] = '{len: 16, exp_busy: 1'b1, exp_err_req: 1'b0, exp_err_abort: 1'b1};
        vecs[5] = '{len: 8,  exp_busy: 1'b1, exp_err_req: 1'b0, exp_err_abort: 1'b1};

        for (int j = 0; j < 2; j++) begin
            for (int a = 0; a < 16; a++) begin
                ram_m[j][a] = 8'h00;
                exp_m[j][a] = 8'h00;
            end
        end

        // reset state
        rst = 1'b1;
        idle_inputs();
        in_valid = 1'b1;
        cpu_addr = 4'h5;
        #1;
        check("rst_busy0", busy_0, 0);
        check("rst_hold1", cpu_hold_1, 0);
        check("rst_ready0", in_ready_0, 0);
        check("rst_we1", ram_we_1, 0);
        check("rst_done0", done_0, 0);
        check("rst_err1", err_1, 0);
        check("rst_addr0", ram_addr_0, 5);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        step();

        // length legality and abort handling, one record per case
        for (int v = 0; v < 6; v++) begin
            idle_inputs();
            load_req = 1'b1;
            load_len = 5'(vecs[v].len);
            step();
            idle_inputs();
            step();
            for (int j = 0; j < 2; j++) begin
                check($sformatf("vec%0d_busy%0d", v, j), s_busy[j], vecs[v].exp_busy);
                check($sformatf("vec%0d_hold%0d", v, j), s_hold[j], vecs[v].exp_busy);
                check($sformatf("vec%0d_err_req%0d", v, j), s_err[j], vecs[v].exp_err_req);
                check($sformatf("vec%0d_we%0d", v, j), s_we[j], 0);
            end
            idle_inputs();
            load_abort = 1'b1;
            in_valid   = 1'b1;
            step();
            for (int j = 0; j < 2; j++) begin
                check($sformatf("vec%0d_abort_rdy%0d", v, j), s_rdy[j], 0);
                check($sformatf("vec%0d_abort_we%0d", v, j), s_we[j], 0);
            end
            idle_inputs();
            step();
            for (int j = 0; j < 2; j++) begin
                check($sformatf("vec%0d_err_abort%0d", v, j), s_err[j], vecs[v].exp_err_abort);
                check($sformatf("vec%0d_after_busy%0d", v, j), s_busy[j], 0);
            end
            step();
        end

        // three back-to-back bytes
        data_b[0] = 8'h1E; data_b[1] = 8'h2F; data_b[2] = 8'hE0;
        run_load(3, 1'b0, 0, 0, 0);

        // two bytes with a three-cycle valid gap
        data_b[0] = 8'hA5; data_b[1] = 8'h5A;
        run_load(2, 1'b0, 0, 3, 0);

        // fourteen bytes: two fill cycles on the zero-fill instance
        for (int i = 0; i < 16; i++) data_b[i] = 8'($urandom_range(1, 255));
        run_load(14, 1'b0, 0, 0, 0);

        // abort on the second byte of a four-byte load, then MAR passthrough
        for (int i = 0; i < 16; i++) data_b[i] = 8'($urandom);
        run_load(4, 1'b1, 1, 0, 0);
        idle_inputs();
        cpu_addr = 4'h9;
        step();
        check("post_abort_addr0", s_addr[0], 9);
        check("post_abort_addr1", s_addr[1], 9);

        // asynchronous reset in the middle of FILL
        idle_inputs();
        load_req = 1'b1;
        load_len = 5'd4;
        step();
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            step();
        end
        idle_inputs();
        step();
        step();
        check("fill_active_busy1", s_busy[1], 1);
        check("fill_active_we1", s_we[1], 1);
        rst = 1'b1;
        #1;
        check("mid_fill_rst_hold1", cpu_hold_1, 0);
        check("mid_fill_rst_we1", ram_we_1, 0);
        check("mid_fill_rst_busy1", busy_1, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        for (int i = 0; i < 16; i++) data_b[i] = 8'($urandom);
        run_load(16, 1'b0, 0, 0, 1);

        // randomized loads, some aborted
        for (int r = 0; r < 25; r++) begin
            int len;
            bit ab;
            len = $urandom_range(1, 16);
            ab  = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 16; i++) data_b[i] = 8'($urandom);
            run_load(len, ab, $urandom_range(0, len - 1), 0, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
